// File: rtl/dp_ram_scanner.sv
// Purpose : dual-port word store with per-word dirty tracking, scanned by an external address counter.
// Latency : 1 cycle from an accepted read (scan_en=1) to rd_valid/rd_addr_q/rd_data_q/rd_dirty_q.
// Backpr. : none; a read is accepted every cycle scan_en=1 and overwrites the presented result.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data write port; a write marks the word dirty
//   scan_en/rd_addr       read request; a read clears the word's dirty bit
//   rd_valid              high for one cycle per accepted read
//   rd_addr_q/rd_data_q   address and data of the presented read
//   rd_dirty_q            dirty state of that word before the read cleared it
//   dirty_cnt             population count of the dirty bitmap
module dp_ram_scanner #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              scan_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr_q,
  output logic [DATA_W-1:0] rd_data_q,
  output logic              rd_dirty_q,
  output logic [ADDR_W:0]   dirty_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  dirty;

  logic collision;
  logic rd_clears;
  logic cnt_inc;
  logic cnt_dec;

  // A read that collides with a write to the same word keeps that word dirty:
  // the scanner sees the new data, but the write must still be reported later.
  assign collision = scan_en && wr_en && (wr_addr == rd_addr);
  assign rd_clears = scan_en && !collision;
  assign cnt_inc   = wr_en && !dirty[wr_addr];
  assign cnt_dec   = rd_clears && dirty[rd_addr];

  // Storage has no reset; writes are ignored while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dirty      <= '0;
      dirty_cnt  <= '0;
      rd_valid   <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_dirty_q <= 1'b0;
    end else begin
      // Read clear first, write set second, so a collision leaves the bit set.
      if (rd_clears) begin
        dirty[rd_addr] <= 1'b0;
      end
      if (wr_en) begin
        dirty[wr_addr] <= 1'b1;
      end

      case ({cnt_inc, cnt_dec})
        2'b10:   dirty_cnt <= dirty_cnt + 1'b1;
        2'b01:   dirty_cnt <= dirty_cnt - 1'b1;
        default: dirty_cnt <= dirty_cnt;
      endcase

      rd_valid <= scan_en;
      if (scan_en) begin
        rd_addr_q  <= rd_addr;
        rd_data_q  <= collision ? wr_data : mem[rd_addr];
        rd_dirty_q <= collision ? 1'b1    : dirty[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_dp_ram_scanner.sv
// Directed bench for dp_ram_scanner: write/scan/collision/count/reset scenarios.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_dp_ram_scanner;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic       scan_en;
  logic [4:0] rd_addr;
  logic       rd_valid;
  logic [4:0] rd_addr_q;
  logic [3:0] rd_data_q;
  logic       rd_dirty_q;
  logic [5:0] dirty_cnt;

  int errors = 0;
  int checks = 0;

  dp_ram_scanner #(.DATA_W(4), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .scan_en    (scan_en),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_addr_q  (rd_addr_q),
    .rd_data_q  (rd_data_q),
    .rd_dirty_q (rd_dirty_q),
    .dirty_cnt  (dirty_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    scan_en = 1'b0;
  endtask

  task automatic check_rd(input string tag, input int vld, input int addr,
                          input int data, input int dirt, input int cnt);
    check({tag, ".vld"},   32'(rd_valid),   32'(vld));
    check({tag, ".addr"},  32'(rd_addr_q),  32'(addr));
    check({tag, ".data"},  32'(rd_data_q),  32'(data));
    check({tag, ".dirty"}, 32'(rd_dirty_q), 32'(dirt));
    check({tag, ".cnt"},   32'(dirty_cnt),  32'(cnt));
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; scan_en = 1'b0; rd_addr = '0;
    step();
    step();
    check_rd("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Write 0xA to 3, then scan it twice.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 4'hA;
    step();
    check("wr3.cnt", 32'(dirty_cnt), 32'd1);
    check("wr3.vld", 32'(rd_valid), 32'd0);
    wr_en = 1'b0; scan_en = 1'b1; rd_addr = 5'd3;
    step();
    check_rd("scan3a", 1, 3, 'hA, 1, 0);
    step();
    check_rd("scan3b", 1, 3, 'hA, 0, 0);

    // scan_en low: no valid, outputs held.
    idle();
    step();
    check_rd("hold1", 0, 3, 'hA, 0, 0);

    // Collision on 7: bypass data, bit stays set.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 4'h5; scan_en = 1'b1; rd_addr = 5'd7;
    step();
    check_rd("coll7", 1, 7, 5, 1, 1);
    wr_en = 1'b0;
    step();
    check_rd("rescan7", 1, 7, 5, 1, 0);

    // Simultaneous set of clean 2 and clear of dirty 9.
    idle();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 4'h9;
    step();
    check("wr9.cnt", 32'(dirty_cnt), 32'd1);
    wr_addr = 5'd2; wr_data = 4'h2; scan_en = 1'b1; rd_addr = 5'd9;
    step();
    check_rd("wr2rd9", 1, 9, 9, 1, 1);
    scan_en = 1'b0; wr_addr = 5'd2; wr_data = 4'h6;
    step();
    check("rewr2.cnt", 32'(dirty_cnt), 32'd1);
    check("rewr2.vld", 32'(rd_valid), 32'd0);
    wr_en = 1'b0; scan_en = 1'b1; rd_addr = 5'd2;
    step();
    check_rd("scan2", 1, 2, 6, 1, 0);

    // Fill all 32 words, then sweep with wrap back to 0.
    idle();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 4'(i);
      step();
    end
    wr_en = 1'b0;
    check("fill.cnt", 32'(dirty_cnt), 32'd32);
    scan_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      step();
      check_rd($sformatf("sweep%0d", i), 1, i, i & 15, 1, 31 - i);
    end
    rd_addr = 5'd0;
    step();
    check_rd("wrap0", 1, 0, 0, 0, 0);

    // Build dirty_cnt=5, then reset mid-sweep with a write and read pending.
    idle();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 4'(i + 8);
      step();
    end
    wr_en = 1'b0; scan_en = 1'b1;
    rd_addr = 5'd10;
    step();
    check_rd("pre10", 1, 10, 10, 0, 5);
    rd_addr = 5'd11;
    step();
    check_rd("pre11", 1, 11, 11, 0, 5);
    reset = 1'b1; rd_addr = 5'd12; wr_en = 1'b1; wr_addr = 5'd20; wr_data = 4'hF;
    step();
    check_rd("midrst", 0, 0, 0, 0, 0);
    reset = 1'b0; wr_en = 1'b0; scan_en = 1'b1; rd_addr = 5'd0;
    step();
    check_rd("post0", 1, 0, 8, 0, 0);
    rd_addr = 5'd20;
    step();
    check_rd("post20", 1, 20, 4, 0, 0);
    idle();
    step();
    check_rd("hold2", 0, 20, 4, 0, 0);
    step();
    check_rd("hold3", 0, 20, 4, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_ram_scanner.md
DP_RAM_SCANNER -- requirements
Module: dp_ram_scanner

Interface
REQ-001 Parameter DATA_W, default 4, data word width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth = 2^ADDR_W words (32 at default).
REQ-003 Clock and reset: reset reset, synchronous, active-high; clock clk.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 wr_en  input  1  write strobe, sampled on the rising edge.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  DATA_W  write data.
REQ-009 scan_en  input  1  read-request qualifier for rd_addr this cycle.
REQ-010 rd_addr  input  ADDR_W  scan address, driven by the upstream free-running 5-bit address counter.
REQ-011 rd_valid  output  1  registered; high when rd_addr_q/rd_data_q/rd_dirty_q hold a completed read.
REQ-012 rd_addr_q  output  ADDR_W  registered; address of the read being presented.
REQ-013 rd_data_q  output  DATA_W  registered; data at rd_addr_q.
REQ-014 rd_dirty_q  output  1  registered; word written since its last scan.
REQ-015 dirty_cnt  output  ADDR_W+1  registered; number of dirty words, range 0..2^ADDR_W.

Function
REQ-016 Storage: 2^ADDR_W x DATA_W array, one write port and one read port, both in clk domain.
REQ-017 Write: wr_en=1 at an edge stores wr_data at wr_addr and sets dirty[wr_addr]; wr_en=0 leaves the array unchanged.
REQ-018 Read latency: exactly 1 cycle; rd_addr/scan_en sampled at edge N drive rd_valid/rd_addr_q/rd_data_q/rd_dirty_q after edge N.
REQ-019 scan_en=0 at edge N: rd_valid=0 after edge N; rd_addr_q/rd_data_q/rd_dirty_q hold previous values; no dirty bit is cleared by the read port.
REQ-020 scan_en=1, no address collision: rd_data_q = stored word, rd_dirty_q = dirty[rd_addr] before the edge, dirty[rd_addr] cleared at that edge.
REQ-021 Collision (scan_en=1, wr_en=1, wr_addr==rd_addr): write-first bypass; rd_data_q=wr_data, rd_dirty_q=1, dirty bit remains 1.
REQ-022 dirty_cnt update per edge: +1 if a write sets a clean bit; -1 if a read clears a set bit at a different address; both or neither -> unchanged; write to already-dirty word -> unchanged.
REQ-023 dirty_cnt never wraps; it equals the population count of the dirty bitmap after every edge.
REQ-024 rd_addr wrap (31 -> 0 from the upstream counter) needs no special handling; reads stay back-to-back, one per cycle.
REQ-025 No back-pressure: a new read is accepted every cycle scan_en=1; presented results are overwritten on the next accepted read.

Reset
REQ-026 reset=1 at an edge: rd_valid=0, rd_addr_q=0, rd_data_q=0, rd_dirty_q=0, dirty_cnt=0, all dirty bits cleared; reset takes priority over wr_en and scan_en that cycle.
REQ-027 Array contents are not reset; words read before being written return unspecified data with rd_dirty_q=0.
REQ-028 Reset mid-scan: the first read accepted after reset deasserts is presented 1 cycle later with rd_dirty_q=0 unless written after reset.

Verification
REQ-029 Reset, then write 0xA to addr 3; next cycle scan_en=1, rd_addr=3 -> following cycle rd_valid=1, rd_addr_q=3, rd_data_q=0xA, rd_dirty_q=1; dirty_cnt 1 -> 0.
REQ-030 Same address 3 scanned again with no write -> rd_data_q=0xA, rd_dirty_q=0, dirty_cnt=0.
REQ-031 Collision: wr_en=1, wr_addr=rd_addr=7, wr_data=0x5, scan_en=1 -> next cycle rd_data_q=0x5, rd_dirty_q=1, dirty_cnt=1.
REQ-032 Write all 32 addresses with data=addr[3:0] -> dirty_cnt=32; sweep rd_addr 0..31 then wrap to 0 with scan_en=1 -> each result matches, dirty_cnt reaches 0, second pass at addr 0 shows rd_dirty_q=0.
REQ-033 Same edge: write clean addr 2, read dirty addr 9 -> dirty_cnt unchanged; write already-dirty addr 2 alone -> unchanged.
REQ-034 Reset asserted mid-sweep with dirty_cnt=5 -> next cycle all outputs 0, dirty_cnt=0; scan_en=0 cycles -> rd_valid=0 and held outputs.
